// File: rtl/cm0_pmu_sleep_ctrl.sv
// Sleep sequencer driving the HCLK clock-gate ENABLE: entry hold-off, gating, wake settle.
// Optional deep-sleep domain enable is built when CM0_PMU_DEEPSLEEP_EN is defined.
module cm0_pmu_sleep_ctrl #(
    parameter int unsigned ACG       = 1,
    parameter int unsigned ENTRY_DLY = 4,
    parameter int unsigned EXIT_DLY  = 2
) (
    input  logic       FCLK,
    input  logic       PORESETn,
    input  logic       SLEEPING,
    input  logic       SLEEPDEEP,
    input  logic       WAKEUP,
    input  logic       DBGPWRUP,
    output logic       HCLK_EN,
    output logic       DEEP_EN,
    output logic       WAKE_DONE,
    output logic [1:0] PMU_STATE
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ENTRY = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hclk_en_q, hclk_en_d;
    logic               wake_done_q, wake_done_d;
    logic               hold_c;

    assign hold_c = WAKEUP | DBGPWRUP;

    // Next-state decode; counter is loaded on state entry and counts down to zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if ((ACG != 0) && SLEEPING && !hold_c) begin
                    state_d = ST_ENTRY;
                    cnt_d   = CNT_W'(ENTRY_DLY);
                end
            end
            ST_ENTRY: begin
                if (hold_c || !SLEEPING) begin
                    state_d = ST_RUN;
                end else if (cnt_q == '0) begin
                    state_d = ST_GATED;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GATED: begin
                if (hold_c) begin
                    state_d = ST_WAKE;
                    cnt_d   = CNT_W'(EXIT_DLY);
                end
            end
            ST_WAKE: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
        // Enables decoded from the next state so the gate sees a clean registered level.
        hclk_en_d   = (state_d != ST_GATED);
        wake_done_d = (state_q == ST_WAKE) && (state_d == ST_RUN);
    end

`ifdef CM0_PMU_DEEPSLEEP_EN
    logic sd_cap_q, sd_cap_d;
    logic deep_en_q, deep_en_d;

    // SLEEPDEEP is only sampled on the ENTRY->GATED transition.
    always_comb begin
        sd_cap_d = sd_cap_q;
        if ((state_q == ST_ENTRY) && (state_d == ST_GATED)) begin
            sd_cap_d = SLEEPDEEP;
        end
        deep_en_d = !((state_d == ST_GATED) && sd_cap_d);
    end

    assign DEEP_EN = deep_en_q;
`else
    logic unused_sleepdeep;

    assign unused_sleepdeep = SLEEPDEEP;
    assign DEEP_EN          = 1'b1;
`endif

    always_ff @(posedge FCLK or negedge PORESETn) begin
        if (!PORESETn) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            hclk_en_q   <= 1'b1;
            wake_done_q <= 1'b0;
`ifdef CM0_PMU_DEEPSLEEP_EN
            sd_cap_q    <= 1'b0;
            deep_en_q   <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hclk_en_q   <= hclk_en_d;
            wake_done_q <= wake_done_d;
`ifdef CM0_PMU_DEEPSLEEP_EN
            sd_cap_q    <= sd_cap_d;
            deep_en_q   <= deep_en_d;
`endif
        end
    end

    assign HCLK_EN   = hclk_en_q;
    assign WAKE_DONE = wake_done_q;
    assign PMU_STATE = state_q;

endmodule

// File: tb/tb_cm0_pmu_sleep_ctrl.sv
// Directed table-driven bench for cm0_pmu_sleep_ctrl (default, zero-delay and no-ACG instances).
module tb_cm0_pmu_sleep_ctrl;

    logic FCLK = 1'b0;
    logic PORESETn = 1'b0;
    logic SLEEPING = 1'b0;
    logic SLEEPDEEP = 1'b0;
    logic WAKEUP = 1'b0;
    logic DBGPWRUP = 1'b0;

    logic       hclk_a, deep_a, done_a;
    logic [1:0] st_a;
    logic       hclk_z, deep_z, done_z;
    logic [1:0] st_z;
    logic       hclk_n, deep_n, done_n;
    logic [1:0] st_n;

    int ncmp = 0;
    int nerr = 0;

    always #5 FCLK = ~FCLK;

    cm0_pmu_sleep_ctrl #(.ACG(1), .ENTRY_DLY(4), .EXIT_DLY(2)) dut_a (
        .FCLK(FCLK), .PORESETn(PORESETn), .SLEEPING(SLEEPING), .SLEEPDEEP(SLEEPDEEP),
        .WAKEUP(WAKEUP), .DBGPWRUP(DBGPWRUP), .HCLK_EN(hclk_a), .DEEP_EN(deep_a),
        .WAKE_DONE(done_a), .PMU_STATE(st_a));

    cm0_pmu_sleep_ctrl #(.ACG(1), .ENTRY_DLY(0), .EXIT_DLY(0)) dut_z (
        .FCLK(FCLK), .PORESETn(PORESETn), .SLEEPING(SLEEPING), .SLEEPDEEP(SLEEPDEEP),
        .WAKEUP(WAKEUP), .DBGPWRUP(DBGPWRUP), .HCLK_EN(hclk_z), .DEEP_EN(deep_z),
        .WAKE_DONE(done_z), .PMU_STATE(st_z));

    cm0_pmu_sleep_ctrl #(.ACG(0), .ENTRY_DLY(4), .EXIT_DLY(2)) dut_n (
        .FCLK(FCLK), .PORESETn(PORESETn), .SLEEPING(SLEEPING), .SLEEPDEEP(SLEEPDEEP),
        .WAKEUP(WAKEUP), .DBGPWRUP(DBGPWRUP), .HCLK_EN(hclk_n), .DEEP_EN(deep_n),
        .WAKE_DONE(done_n), .PMU_STATE(st_n));

    // rst: reset before this record; sel: 0 = dut_a, 1 = dut_z; dm: DEEP_EN when the option is built
    typedef struct packed {
        logic       rst;
        logic       sel;
        logic       sl;
        logic       sd;
        logic       wk;
        logic       dbg;
        logic [1:0] st;
        logic       h;
        logic       d;
        logic       dm;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(bit rst, bit sel, bit sl, bit sd, bit wk, bit dbg,
                                logic [1:0] st, bit h, bit d, bit dm);
        vec_t v;
        v.rst = rst; v.sel = sel; v.sl = sl; v.sd = sd; v.wk = wk; v.dbg = dbg;
        v.st = st; v.h = h; v.d = d; v.dm = dm;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [4:0] act,
                       input logic [4:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s v%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    function automatic logic exp_deep(input logic dm);
`ifdef CM0_PMU_DEEPSLEEP_EN
        return dm;
`else
        return 1'b1;
`endif
    endfunction

    task automatic do_reset();
        @(negedge FCLK);
        PORESETn = 1'b0;
        SLEEPING = 1'b0; SLEEPDEEP = 1'b0; WAKEUP = 1'b0; DBGPWRUP = 1'b0;
        #1;
        chk("reset_state", -1, {3'b0, st_a}, 5'd0);
        chk("reset_outs", -1, {2'b0, hclk_a, done_a, deep_a}, 5'b00101);
        repeat (2) @(negedge FCLK);
        PORESETn = 1'b1;
    endtask

    initial begin
        // Test 1: full sleep/wake with SLEEPDEEP=1, then re-entry and abort on ~SLEEPING
        vq.push_back(mk(1, 0, 1, 1, 0, 0, 2'd1, 1, 0, 1));
        for (int i = 1; i <= 4; i++) vq.push_back(mk(0, 0, 1, 1, 0, 0, 2'd1, 1, 0, 1));
        for (int i = 5; i <= 9; i++) vq.push_back(mk(0, 0, 1, 1, 0, 0, 2'd2, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 1, 1, 0, 2'd3, 1, 0, 1));
        vq.push_back(mk(0, 0, 1, 1, 0, 0, 2'd3, 1, 0, 1));
        vq.push_back(mk(0, 0, 1, 1, 0, 0, 2'd3, 1, 0, 1));
        vq.push_back(mk(0, 0, 1, 1, 0, 0, 2'd0, 1, 1, 1));
        vq.push_back(mk(0, 0, 1, 1, 0, 0, 2'd1, 1, 0, 1));
        vq.push_back(mk(0, 0, 0, 1, 0, 0, 2'd0, 1, 0, 1));
        // Test 2: DBGPWRUP abort, then RUN with sleep and hold together stays RUN
        vq.push_back(mk(1, 0, 1, 0, 0, 0, 2'd1, 1, 0, 1));
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 2'd1, 1, 0, 1));
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 2'd1, 1, 0, 1));
        vq.push_back(mk(0, 0, 1, 0, 0, 1, 2'd0, 1, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 1, 0, 1));
        vq.push_back(mk(0, 0, 1, 0, 1, 0, 2'd0, 1, 0, 1));
        vq.push_back(mk(0, 0, 1, 0, 0, 1, 2'd0, 1, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 1, 0, 1));
        // Test 3: WAKEUP on the cycle the ENTRY counter is zero aborts to RUN
        vq.push_back(mk(1, 0, 1, 1, 0, 0, 2'd1, 1, 0, 1));
        for (int i = 1; i <= 4; i++) vq.push_back(mk(0, 0, 1, 1, 0, 0, 2'd1, 1, 0, 1));
        vq.push_back(mk(0, 0, 1, 1, 1, 0, 2'd0, 1, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 1, 0, 1));
        // Test 6b: SLEEPDEEP=0 at capture keeps DEEP_EN high even if it rises later
        vq.push_back(mk(1, 0, 1, 0, 0, 0, 2'd1, 1, 0, 1));
        for (int i = 1; i <= 4; i++) vq.push_back(mk(0, 0, 1, 0, 0, 0, 2'd1, 1, 0, 1));
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 2'd2, 0, 0, 1));
        vq.push_back(mk(0, 0, 1, 1, 0, 0, 2'd2, 0, 0, 1));
        vq.push_back(mk(0, 0, 1, 1, 1, 0, 2'd3, 1, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 2'd3, 1, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 2'd3, 1, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 1, 1, 1));
        // Test 5: zero delays on dut_z, SLEEPDEEP=1 at capture
        vq.push_back(mk(1, 1, 1, 0, 0, 0, 2'd1, 1, 0, 1));
        vq.push_back(mk(0, 1, 1, 1, 0, 0, 2'd2, 0, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 1, 0, 2'd3, 1, 0, 1));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 2'd0, 1, 1, 1));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 2'd0, 1, 0, 1));

        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            logic [1:0] st;
            logic h, d, dp;
            v = vq[i];
            if (v.rst) do_reset();
            @(negedge FCLK);
            SLEEPING = v.sl; SLEEPDEEP = v.sd; WAKEUP = v.wk; DBGPWRUP = v.dbg;
            @(posedge FCLK);
            #1;
            st = v.sel ? st_z : st_a;
            h  = v.sel ? hclk_z : hclk_a;
            d  = v.sel ? done_z : done_a;
            dp = v.sel ? deep_z : deep_a;
            chk("state", i, {3'b0, st}, {3'b0, v.st});
            chk("hclk_en", i, {4'b0, h}, {4'b0, v.h});
            chk("wake_done", i, {4'b0, d}, {4'b0, v.d});
            chk("deep_en", i, {4'b0, dp}, {4'b0, exp_deep(v.dm)});
            chk("noacg", i, {st_n, hclk_n, done_n, deep_n}, 5'b00101);
        end

        // Test 4: asynchronous reset while GATED
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge FCLK);
            SLEEPING = 1'b1; SLEEPDEEP = 1'b1;
        end
        @(posedge FCLK);
        #1;
        chk("pre_rst_state", 100, {3'b0, st_a}, 5'd2);
        chk("pre_rst_hclk", 100, {4'b0, hclk_a}, 5'd0);
        #2;
        PORESETn = 1'b0;
        #1;
        chk("async_rst_hclk", 101, {4'b0, hclk_a}, 5'd1);
        chk("async_rst_state", 101, {3'b0, st_a}, 5'd0);
        chk("async_rst_done", 101, {4'b0, done_a}, 5'd0);
        chk("async_rst_deep", 101, {4'b0, deep_a}, 5'd1);
        SLEEPING = 1'b0; SLEEPDEEP = 1'b0;
        @(negedge FCLK);
        PORESETn = 1'b1;
        repeat (2) @(negedge FCLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
